iob_ram_be_bist: RTL

- Single-port initiator that drives one port of a byte-enabled synchronous RAM, such as one port of the team's dual-port byte-enable RAMs.
- Writes an incremental pattern `addr+seq_ini` to every location with all byte enables set, reads every location back, and compares the result.
- Used as a power-up or on-demand memory self-test. Also used as the reusable stimulus engine in RAM benches.
- The RAM has 1-cycle read latency: data appears the cycle after `en` is asserted with `we=0`.

---
 rtl/iob_ram_be_bist_pkg.sv | 31 +++
 rtl/iob_ram_be_bist_cmp.sv | 35 +++
 rtl/iob_ram_be_bist.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/iob_ram_be_bist_pkg.sv
// iob_ram_be_bist_pkg: state encoding and sizing shared by the RAM BIST.
// IOB_RAM_BIST_INV_PASS_EN adds the states of the inverted-data second pass.
package iob_ram_be_bist_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;
    localparam int BE_W       = DATA_W_DEF / 8;
    localparam int N_WORDS    = 2 ** ADDR_W_DEF;

`ifdef IOB_RAM_BIST_INV_PASS_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        READ   = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4,
        WRITE2 = 3'd5,
        READ2  = 3'd6,
        CHECK2 = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;
`endif

endpackage

// File: rtl/iob_ram_be_bist_cmp.sv
// iob_ram_be_bist_cmp: one-stage read-compare pipeline; holds expected data and
// address of the read the RAM sampled last edge and flags a mismatch on its data.
module iob_ram_be_bist_cmp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              issue,
    input  logic [DATA_W-1:0] expData,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] rdData,
    output logic              mismatch,
    output logic [ADDR_W-1:0] cmpAddr
);

    logic              valid;
    logic [DATA_W-1:0] expReg;

    // A mismatch aborts the test, so the read in flight behind it is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid   <= 1'b0;
            expReg  <= '0;
            cmpAddr <= '0;
        end else begin
            valid   <= issue && !mismatch;
            expReg  <= expData;
            cmpAddr <= addr;
        end
    end

    assign mismatch = valid && (rdData != expReg);

endmodule

// File: rtl/iob_ram_be_bist.sv
// iob_ram_be_bist: write addr+seq_ini to every RAM word, read back and compare.
// Define IOB_RAM_BIST_INV_PASS_EN for a second pass with inverted data.
module iob_ram_be_bist
    import iob_ram_be_bist_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [DATA_W-1:0]   seq_ini_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                fail_o,
    output logic [ADDR_W-1:0]   fail_addr_o,
    output logic [DATA_W-1:0]   fail_data_o,
    output logic                ram_en_o,
    output logic [DATA_W/8-1:0] ram_we_o,
    output logic [ADDR_W-1:0]   ram_addr_o,
    output logic [DATA_W-1:0]   ram_d_o,
    input  logic [DATA_W-1:0]   ram_d_i
);

    localparam int beW = DATA_W / 8;

    state_t            state, stateNext;
    logic [ADDR_W-1:0] cnt, cntNext, addrNext, failAddrNext, cmpAddr;
    logic [DATA_W-1:0] seq, seqNext, dNext, failDataNext, pattern;
    logic [beW-1:0]    weNext;
    logic              busyNext, doneNext, failNext, enNext, wrNext, rdNext;
    logic              lastAddr, mismatch;

    assign lastAddr = &cnt;

    iob_ram_be_bist_cmp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) cmp (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .issue    (ram_en_o && ram_we_o == '0),
        .expData  (ram_d_o),
        .addr     (ram_addr_o),
        .rdData   (ram_d_i),
        .mismatch (mismatch),
        .cmpAddr  (cmpAddr)
    );

    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        seqNext      = seq;
        failNext     = fail_o;
        failAddrNext = fail_addr_o;
        failDataNext = fail_data_o;
        case (state)
            IDLE, DONE: if (start_i) begin
                stateNext    = WRITE;
                cntNext      = '0;
                seqNext      = seq_ini_i;
                failNext     = 1'b0;
                failAddrNext = '0;
                failDataNext = '0;
            end
            WRITE: begin
                cntNext   = lastAddr ? '0 : cnt + 1'b1;
                stateNext = lastAddr ? READ : WRITE;
            end
            READ: begin
                cntNext   = lastAddr ? '0 : cnt + 1'b1;
                stateNext = lastAddr ? CHECK : READ;
            end
`ifdef IOB_RAM_BIST_INV_PASS_EN
            CHECK: stateNext = WRITE2;
            WRITE2: begin
                cntNext   = lastAddr ? '0 : cnt + 1'b1;
                stateNext = lastAddr ? READ2 : WRITE2;
            end
            READ2: begin
                cntNext   = lastAddr ? '0 : cnt + 1'b1;
                stateNext = lastAddr ? CHECK2 : READ2;
            end
            CHECK2: stateNext = DONE;
`else
            CHECK: stateNext = DONE;
`endif
            default: stateNext = IDLE;
        endcase
        // Only reads feed the compare pipe, so a mismatch implies a read/check state.
        if (mismatch) begin
            stateNext    = DONE;
            failNext     = 1'b1;
            failAddrNext = cmpAddr;
            failDataNext = ram_d_i;
        end
`ifdef IOB_RAM_BIST_INV_PASS_EN
        wrNext   = stateNext inside {WRITE, WRITE2};
        rdNext   = stateNext inside {READ, READ2};
        busyNext = wrNext || rdNext || stateNext inside {CHECK, CHECK2};
        pattern  = (DATA_W'(cntNext) + seqNext) ^ {DATA_W{stateNext inside {WRITE2, READ2}}};
`else
        wrNext   = stateNext == WRITE;
        rdNext   = stateNext == READ;
        busyNext = wrNext || rdNext || stateNext == CHECK;
        pattern  = DATA_W'(cntNext) + seqNext;
`endif
        enNext   = wrNext || rdNext;
        weNext   = {beW{wrNext}};
        addrNext = enNext ? cntNext : '0;
        dNext    = enNext ? pattern : '0;
        doneNext = stateNext == DONE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            seq         <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_data_o <= '0;
            ram_en_o    <= 1'b0;
            ram_we_o    <= '0;
            ram_addr_o  <= '0;
            ram_d_o     <= '0;
        end else begin
            state       <= stateNext;
            cnt         <= cntNext;
            seq         <= seqNext;
            busy_o      <= busyNext;
            done_o      <= doneNext;
            fail_o      <= failNext;
            fail_addr_o <= failAddrNext;
            fail_data_o <= failDataNext;
            ram_en_o    <= enNext;
            ram_we_o    <= weNext;
            ram_addr_o  <= addrNext;
            ram_d_o     <= dNext;
        end
    end

endmodule
